// File: rtl/mod_addsub_front.sv
// Two-stage front end of a modular adder/subtractor.
// Stage 1 captures the operands, modulus and operation together with a range
// check. Stage 2 holds the uncorrected sum/difference (v), the
// modulus-corrected candidate (w) and the select bit (b4) for the third stage.
// Both stages use valid/ready handshakes, so a stall downstream propagates
// back without losing or duplicating beats.
module mod_addsub_front (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] m,
    input  logic       s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] v,
    output logic [4:0] w,
    output logic       s_o,
    output logic       b4,
    output logic       err,
    output logic [7:0] err_cnt
);

    // A beat is unusable when the modulus is zero or an operand is not
    // already reduced modulo m.
    function automatic logic range_err(input logic [3:0] op_a,
                                       input logic [3:0] op_b,
                                       input logic [3:0] modulus);
        return (modulus == 4'd0) || (op_a >= modulus) || (op_b >= modulus);
    endfunction

    // Stage 1 registers
    logic       s1_valid_r;
    logic [3:0] s1_a_r;
    logic [3:0] s1_b_r;
    logic [3:0] s1_m_r;
    logic       s1_s_r;
    logic       s1_err_r;

    // Stage 2 registers
    logic       s2_valid_r;
    logic [4:0] s2_v_r;
    logic [4:0] s2_w_r;
    logic       s2_b4_r;
    logic       s2_s_r;
    logic       s2_err_r;
    logic [7:0] err_cnt_r;

    // Handshake and datapath wires
    logic       s2_load_s;
    logic       s1_load_s;
    logic       accept_s;
    logic       in_err_s;
    logic [4:0] sum_s;
    logic [4:0] diff_s;
    logic [4:0] m5_s;
    logic [4:0] v_s;
    logic [4:0] w_s;
    logic       b4_s;

    // Stage 2 moves when it is empty or its beat is being taken; stage 1
    // moves when it is empty or stage 2 is pulling its beat forward.
    always_comb begin
        s2_load_s = (~s2_valid_r) | out_ready;
        s1_load_s = (~s1_valid_r) | s2_load_s;
        accept_s  = in_valid & s1_load_s;
        in_err_s  = range_err(a, b, m);
    end

    assign in_ready = s1_load_s;

    // Stage 1 arithmetic: both the plain and the corrected value are formed
    // so the third stage only has to pick one using b4.
    always_comb begin
        m5_s   = {1'b0, s1_m_r};
        sum_s  = {1'b0, s1_a_r} + {1'b0, s1_b_r};
        diff_s = {1'b0, s1_a_r} - {1'b0, s1_b_r};
        v_s    = 5'd0;
        w_s    = 5'd0;
        b4_s   = 1'b0;
        if (s1_err_r) begin
            v_s  = 5'd0;
            w_s  = 5'd0;
            b4_s = 1'b0;
        end else if (s1_s_r == 1'b0) begin
            v_s  = sum_s;
            w_s  = sum_s - m5_s;
            b4_s = (sum_s >= m5_s);
        end else begin
            v_s  = diff_s;
            w_s  = diff_s + m5_s;
            b4_s = (s1_a_r < s1_b_r);
        end
    end

    // Stage 1 capture of operands, modulus, operation and range check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= 4'd0;
            s1_b_r     <= 4'd0;
            s1_m_r     <= 4'd0;
            s1_s_r     <= 1'b0;
            s1_err_r   <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r   <= a;
                s1_b_r   <= b;
                s1_m_r   <= m;
                s1_s_r   <= s;
                s1_err_r <= in_err_s;
            end
        end
    end

    // Stage 2 capture of the result beat; held unchanged while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_v_r     <= 5'd0;
            s2_w_r     <= 5'd0;
            s2_b4_r    <= 1'b0;
            s2_s_r     <= 1'b0;
            s2_err_r   <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_v_r   <= v_s;
                s2_w_r   <= w_s;
                s2_b4_r  <= b4_s;
                s2_s_r   <= s1_s_r;
                s2_err_r <= s1_err_r;
            end
        end
    end

    // Saturating count of erroneous beats taken in at the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'd0;
        end else if (accept_s && in_err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign out_valid = s2_valid_r;
    assign v         = s2_v_r;
    assign w         = s2_w_r;
    assign b4        = s2_b4_r;
    assign s_o       = s2_s_r;
    assign err       = s2_err_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_mod_addsub_front.sv
// Scoreboard bench for mod_addsub_front: the driver pushes the expected beat
// when the DUT accepts it, and a monitor pops and compares whenever a beat
// leaves the block.
module tb_mod_addsub_front;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic [3:0] m = 4'd0;
    logic       s = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] v;
    logic [4:0] w;
    logic       s_o;
    logic       b4;
    logic       err;
    logic [7:0] err_cnt;

    typedef struct packed {
        logic [4:0] v;
        logic [4:0] w;
        logic       b4;
        logic       s_o;
        logic       err;
        logic [3:0] sel;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    int   cyc = 0;
    logic rand_bp = 1'b0;

    mod_addsub_front dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .v(v), .w(w), .s_o(s_o), .b4(b4), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random back-pressure while enabled
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Expected beat from the arithmetic rules; sel is the true modular result.
    function automatic exp_t model(input int ai, input int bi, input int mi, input int si);
        exp_t e;
        int   vv;
        int   ww;
        e = '0;
        e.s_o = si[0];
        if (mi == 0 || ai >= mi || bi >= mi) begin
            e.err = 1'b1;
        end else begin
            if (si == 0) begin
                vv = ai + bi;
                ww = (vv - mi + 32) % 32;
                e.b4 = (vv >= mi);
                e.sel = 4'((ai + bi) % mi);
            end else begin
                vv = (ai - bi + 32) % 32;
                ww = (vv + mi) % 32;
                e.b4 = (ai < bi);
                e.sel = 4'((((ai - bi) % mi) + mi) % mi);
            end
            e.v = vv[4:0];
            e.w = ww[4:0];
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic send(input int ai, input int bi, input int mi, input int si);
        exp_t e;
        a = ai[3:0];
        b = bi[3:0];
        m = mi[3:0];
        s = si[0];
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(ai, bi, mi, si);
                sb_q.push_back(e);
                if (e.err && model_cnt < 255) model_cnt++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        check("drain_left", sb_q.size(), 0);
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send_valid_random();
        int mi;
        mi = $urandom_range(1, 15);
        send($urandom_range(0, mi - 1), $urandom_range(0, mi - 1), mi, $urandom_range(0, 1));
    endtask

    // Monitor: compares each departing beat and holds-while-stalled stability.
    exp_t        mon_e;
    logic [13:0] prev_out;
    logic        held = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held)
                check("stall_stable", int'({out_valid, v, w, b4, s_o, err}), int'({1'b1, prev_out[12:0]}));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("beat", int'({v, w, b4, s_o, err}),
                          int'({mon_e.v, mon_e.w, mon_e.b4, mon_e.s_o, mon_e.err}));
                    if (!mon_e.err)
                        check("mod_result", int'(b4 ? w : v), int'(mon_e.sel));
                end
            end
            held = out_valid && !out_ready;
            prev_out = {out_valid, v, w, b4, s_o, err};
        end
    end

    initial begin
        int mi;
        int start;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_outputs", int'({v, w, b4, s_o, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Add example with latency check
        out_ready = 1'b1;
        send(9, 7, 13, 0);
        check("lat_edge_n", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_edge_n1", int'(out_valid), 1);
        drain();

        // Subtract examples
        send(2, 5, 13, 1);
        send(5, 2, 13, 1);
        drain();

        // Range error and counter saturation
        send(7, 1, 7, 0);
        drain();
        check("err_cnt_one", int'(err_cnt), 1);
        for (int i = 0; i < 300; i++) begin
            mi = $urandom_range(0, 14);
            send($urandom_range(mi, 15), $urandom_range(0, 15), mi, $urandom_range(0, 1));
        end
        drain();
        check("err_cnt_sat", int'(err_cnt), 255);

        // Back-pressure: two beats fill the pipe, four more wait
        out_ready = 1'b0;
        send(1, 2, 5, 0);
        send(3, 1, 5, 1);
        @(negedge clk);
        check("bp_in_ready", int'(in_ready), 0);
        fork
            begin
                for (int i = 0; i < 4; i++) send_valid_random();
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(7, 1, 7, 0);
        send(3, 3, 2, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_err_cnt", int'(err_cnt), 0);
        sb_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_stale", int'(out_valid), 0);

        // Exhaustive legal operands at full throughput
        start = cyc;
        n = 0;
        for (int mm = 1; mm < 16; mm++)
            for (int aa = 0; aa < mm; aa++)
                for (int bb = 0; bb < mm; bb++)
                    for (int ss = 0; ss < 2; ss++) begin
                        send(aa, bb, mm, ss);
                        n++;
                    end
        check("throughput", cyc - start, n);
        drain();

        // Random operands, including range errors, with random back-pressure
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++)
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        rand_bp = 1'b0;
        drain();
        check("err_cnt_final", int'(err_cnt), model_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
